// File: rtl/gts_ack_sequencer.sv
// gts_ack_sequencer
//   Sequences the genetic toggle switch through its four-phase inducer/ack
//   handshake. Two level requesters (set -> IPTG, clear -> aTc) share the
//   switch under round-robin arbitration; every grant runs one complete
//   handshake: settle, drive inducer, wait ack high, hold, release inducer,
//   wait ack low, settle, done pulse. Each ack wait is bounded by a timeout
//   that parks the FSM in a sticky error state until reset.
//
//   Optional build macro GTS_GFP_CHECK_EN: the reporter (GFP) is sampled when
//   ack falls; a set must leave GFP=1 and a clear GFP=0, otherwise the FSM
//   errors out and the extra sticky output gfp_mismatch is raised.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   set_req      level request for an IPTG handshake
//   clr_req      level request for an aTc handshake
//   ack          handshake acknowledge from the switch
//   GFP          reporter output from the switch
//   IPTG, aTc    registered inducer drives, never both high
//   busy         registered, high whenever the FSM is not idle
//   set_done     one-cycle pulse, set handshake complete
//   clr_done     one-cycle pulse, clear handshake complete
//   timeout_err  sticky error flag (held until rst)
//   gfp_mismatch sticky reporter-check error (GTS_GFP_CHECK_EN only)
module gts_ack_sequencer #(
  parameter int SETTLE_CYCLES  = 5,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES,
  localparam int CNT_W   = $clog2(CNT_MAX + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic set_req,
  input  logic clr_req,
  input  logic ack,
  input  logic GFP,
  output logic IPTG,
  output logic aTc,
  output logic busy,
  output logic set_done,
  output logic clr_done,
`ifdef GTS_GFP_CHECK_EN
  output logic gfp_mismatch,
`endif
  output logic timeout_err
);

  typedef enum logic [2:0] {IDLE, PRE, DRIVE_HI, HOLD, WAIT_LO, POST, ERR} state_t;

  // PRE runs one cycle longer than the other settle phases so the inducer
  // rises SETTLE_CYCLES+1 edges after the grant edge.
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CNT_MAX);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             dir, dir_n;   // 1 = set (IPTG), 0 = clear (aTc)
  logic             ptr, ptr_n;   // preferred requester on a tie, 1 = set
  logic             gfp_bad;
  logic             iptg_n, atc_n, busy_n, set_done_n, clr_done_n, timeout_n;

`ifdef GTS_GFP_CHECK_EN
  logic gfp_mismatch_n;
`else
  logic unused_gfp;
  assign unused_gfp = GFP;
`endif

  // state register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      dir         <= 1'b0;
      ptr         <= 1'b1;
      IPTG        <= 1'b0;
      aTc         <= 1'b0;
      busy        <= 1'b0;
      set_done    <= 1'b0;
      clr_done    <= 1'b0;
      timeout_err <= 1'b0;
`ifdef GTS_GFP_CHECK_EN
      gfp_mismatch <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      dir         <= dir_n;
      ptr         <= ptr_n;
      IPTG        <= iptg_n;
      aTc         <= atc_n;
      busy        <= busy_n;
      set_done    <= set_done_n;
      clr_done    <= clr_done_n;
      timeout_err <= timeout_n;
`ifdef GTS_GFP_CHECK_EN
      gfp_mismatch <= gfp_mismatch_n;
`endif
    end
  end

  // next state, arbitration, phase counter
  always_comb begin
    state_n = state;
    dir_n   = dir;
    ptr_n   = ptr;
    gfp_bad = 1'b0;
    case (state)
      IDLE: begin
        // a still-high ack from a previous handshake blocks new grants
        if (!ack && (set_req || clr_req)) begin
          state_n = PRE;
          dir_n   = set_req && (!clr_req || ptr);
          ptr_n   = !dir_n;
        end
      end
      PRE:      if (cnt == PRE_LAST) state_n = DRIVE_HI;
      DRIVE_HI: begin
        if (ack)                 state_n = HOLD;
        else if (cnt == TO_LAST) state_n = ERR;
      end
      HOLD:     if (cnt == SET_LAST) state_n = WAIT_LO;
      WAIT_LO: begin
        if (!ack) begin
          state_n = POST;
`ifdef GTS_GFP_CHECK_EN
          gfp_bad = (GFP != dir);
          if (gfp_bad) state_n = ERR;
`endif
        end else if (cnt == TO_LAST) begin
          state_n = ERR;
        end
      end
      POST:     if (cnt == SET_LAST) state_n = IDLE;
      ERR:      state_n = ERR;
      default:  state_n = IDLE;
    endcase
    // restart on every phase change, otherwise saturating count
    if (state_n != state)  cnt_n = '0;
    else if (cnt == CNT_SAT) cnt_n = cnt;
    else                   cnt_n = cnt + 1'b1;
  end

  // output next values, derived from the upcoming state
  always_comb begin
    iptg_n     = (state_n == DRIVE_HI || state_n == HOLD) && dir_n;
    atc_n      = (state_n == DRIVE_HI || state_n == HOLD) && !dir_n;
    busy_n     = (state_n != IDLE);
    set_done_n = (state == POST) && (state_n == IDLE) && dir;
    clr_done_n = (state == POST) && (state_n == IDLE) && !dir;
    timeout_n  = (state_n == ERR);
`ifdef GTS_GFP_CHECK_EN
    gfp_mismatch_n = gfp_mismatch || gfp_bad;
`endif
  end

endmodule

// File: tb/tb_gts_ack_sequencer.sv
module tb_gts_ack_sequencer;
  localparam int S = 2;
  localparam int T = 8;

  logic clk = 1'b0;
  logic rst = 1'b1, set_req = 1'b0, clr_req = 1'b0;
  logic ack, GFP;
  logic IPTG, aTc, busy, set_done, clr_done, timeout_err;
`ifdef GTS_GFP_CHECK_EN
  logic gfp_mismatch;
`endif

  gts_ack_sequencer #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .set_req(set_req), .clr_req(clr_req),
    .ack(ack), .GFP(GFP), .IPTG(IPTG), .aTc(aTc), .busy(busy),
    .set_done(set_done), .clr_done(clr_done),
`ifdef GTS_GFP_CHECK_EN
    .gfp_mismatch(gfp_mismatch),
`endif
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // switch model: ack rises after the inducer has been seen high on 4 edges,
  // falls after it has been seen low on 4 edges; GFP follows the last inducer
  int   ack_mode = 1;      // 0 = model, 1 = manual (ack_man)
  logic ack_man = 1'b0, ack_auto = 1'b0, gfp_st = 1'b0, gfp_force = 1'b0;
  logic both_seen = 1'b0;
  int   hc = 0, lc = 0;

  assign ack = (ack_mode != 0) ? ack_man : ack_auto;
  assign GFP = gfp_force ? 1'b0 : gfp_st;

  always @(posedge clk) begin
    #2;
    if (IPTG && aTc) both_seen = 1'b1;
    if (IPTG) gfp_st = 1'b1;
    else if (aTc) gfp_st = 1'b0;
    if (ack_mode != 0) begin
      ack_auto = 1'b0; hc = 0; lc = 0;
    end else if ((IPTG || aTc) && !ack_auto) begin
      hc++; lc = 0;
      if (hc == 4) begin ack_auto = 1'b1; hc = 0; end
    end else if (!(IPTG || aTc) && ack_auto) begin
      lc++; hc = 0;
      if (lc == 4) begin ack_auto = 1'b0; lc = 0; end
    end else begin
      hc = 0; lc = 0;
    end
  end

  // quiet inputs, reset, flush the ack model, then hand ack to the model
  task automatic clean();
    set_req = 1'b0; clr_req = 1'b0; gfp_force = 1'b0;
    ack_mode = 1; ack_man = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    ack_mode = 0;
    both_seen = 1'b0;
  endtask

  initial begin
    int g, rise_c, fall_c, done_c, done_n, r, e, nd;
    logic seen;
    logic [3:0] seq;

    // reset state
    clean();
    chk("reset_outs", {IPTG, aTc, busy, set_done, clr_done, timeout_err}, 0);

    // single set handshake
    set_req = 1'b1; tick(); g = cyc; set_req = 1'b0;
    chk("t1_busy_grant", busy, 1);
    rise_c = -1; fall_c = -1; done_c = -1; done_n = 0; seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (IPTG && rise_c < 0) rise_c = cyc;
      if (!IPTG && rise_c >= 0 && fall_c < 0) fall_c = cyc;
      if (set_done) begin done_n++; if (done_c < 0) done_c = cyc; end
      if (aTc || clr_done) seen = 1'b1;
    end
    chk("t1_iptg_rise", rise_c - g, S + 1);
    chk("t1_iptg_fall", fall_c - g, 9);
    chk("t1_done_cyc", done_c - g, 15);
    chk("t1_done_cnt", done_n, 1);
    chk("t1_no_atc", seen, 0);
    chk("t1_idle", {busy, timeout_err}, 0);

    // both requests held: round-robin alternation
    clean();
    set_req = 1'b1; clr_req = 1'b1;
    nd = 0; seq = '0;
    for (int i = 0; i < 200 && nd < 4; i++) begin
      tick();
      if (set_done || clr_done) begin
        seq[nd] = set_done;
        nd++;
        if (set_done && clr_done) chk("t2_dual_done", 1, 0);
      end
    end
    set_req = 1'b0; clr_req = 1'b0;
    chk("t2_done_count", nd, 4);
    chk("t2_order", seq, 4'b0101);   // seq[0]=set, seq[1]=clr, ...
    chk("t2_exclusive", both_seen, 0);

    // clear with ack never rising: timeout
    clean();
    ack_mode = 1; ack_man = 1'b0;
    clr_req = 1'b1; tick(); g = cyc; clr_req = 1'b0;
    r = -1; e = -1; done_n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (aTc && r < 0) r = cyc;
      if (timeout_err && e < 0) e = cyc;
      if (clr_done) done_n++;
    end
    chk("t3_atc_rise", r - g, S + 1);
    chk("t3_timeout_cyc", e - r, T);
    chk("t3_err_state", {aTc, IPTG, busy, timeout_err}, 4'b0011);
    chk("t3_no_done", done_n, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t3_after_rst", {IPTG, aTc, busy, set_done, clr_done, timeout_err}, 0);

    // stale ack in idle blocks the grant
    clean();
    ack_mode = 1; ack_man = 1'b1; set_req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (IPTG || busy) seen = 1'b1;
    end
    chk("t4_no_grant", seen, 0);
    ack_man = 1'b0;
    tick(); g = cyc;
    tick(); tick();
    chk("t4_iptg_early", IPTG, 0);
    tick();
    chk("t4_iptg_rise", IPTG, 1);
    set_req = 1'b0;

    // reset during HOLD
    clean();
    set_req = 1'b1; tick(); set_req = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("t5_hold_iptg", IPTG, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t5_rst_outs", {IPTG, busy}, 0);
    done_n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (set_done) done_n++;
    end
    chk("t5_no_done", done_n, 0);

`ifdef GTS_GFP_CHECK_EN
    // reporter disagrees with a set handshake
    clean();
    gfp_force = 1'b1;
    set_req = 1'b1; tick(); set_req = 1'b0;
    done_n = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (set_done) done_n++;
    end
    chk("t6_gfp_mismatch", gfp_mismatch, 1);
    chk("t6_err", {timeout_err, busy, IPTG}, 3'b110);
    chk("t6_no_done", done_n, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
